// File: rtl/fetch_resp_buffer_if.sv
// ----------------------------------------------------------------------------
// fetch_resp_buffer_if
//
// Bundles every signal between the fetch response buffer and its neighbours:
//   - fetch side : i_ar_fire, i_ar_addr, i_flush, o_stall
//   - AXI-lite R : i_rvalid, i_rdata, i_rresp, o_rready
//   - decode side: o_valid, i_ready, o_inst, o_pc, o_fault
//
// Modports:
//   slave  - the buffer itself (consumes i_*, drives o_*)
//   master - the environment around it (drives i_*, observes o_*)
// ----------------------------------------------------------------------------
interface fetch_resp_buffer_if #(
  parameter int XLEN = 64
);
  logic            i_ar_fire;
  logic [XLEN-1:0] i_ar_addr;
  logic            i_flush;
  logic            o_stall;

  logic            i_rvalid;
  logic [XLEN-1:0] i_rdata;
  logic [1:0]      i_rresp;
  logic            o_rready;

  logic            o_valid;
  logic            i_ready;
  logic [31:0]     o_inst;
  logic [XLEN-1:0] o_pc;
  logic            o_fault;

  modport slave (
    input  i_ar_fire,
    input  i_ar_addr,
    input  i_flush,
    output o_stall,
    input  i_rvalid,
    input  i_rdata,
    input  i_rresp,
    output o_rready,
    output o_valid,
    input  i_ready,
    output o_inst,
    output o_pc,
    output o_fault
  );

  modport master (
    output i_ar_fire,
    output i_ar_addr,
    output i_flush,
    input  o_stall,
    output i_rvalid,
    output i_rdata,
    output i_rresp,
    input  o_rready,
    input  o_valid,
    output i_ready,
    input  o_inst,
    input  o_pc,
    input  o_fault
  );
endinterface

// File: rtl/fetch_resp_buffer.sv
// ----------------------------------------------------------------------------
// fetch_resp_buffer
//
// Sits between instruction fetch and decode. Every read fired on the AR
// channel has its PC pushed into a tag FIFO; each R beat pops the oldest tag
// and is presented to decode as {instruction, PC, fault} through a one-entry
// output register with a valid/ready handshake.
//
// A redirect (i_flush) throws away every read still in flight. Because the
// memory will still answer those reads, their count is moved into drop_cnt
// and that many future beats are swallowed before tags are consumed again.
// o_stall tells fetch that live plus doomed reads have used the whole budget.
//
// Ports:
//   clk, rstn        clock, synchronous active-low reset
//   bus (slave)      fetch AR notification, flush, stall, AXI-lite R channel,
//                    decode valid/ready/inst/pc/fault
// Parameters:
//   XLEN   data/address width, 32 or 64
//   DEPTH  maximum outstanding reads, power of two >= 2
// ----------------------------------------------------------------------------
module fetch_resp_buffer #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rstn,
  fetch_resp_buffer_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int HI = (XLEN == 64) ? 32 : 0;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  // Picks the 32-bit instruction out of an R beat. On a 64-bit bus the upper
  // word belongs to PCs with bit 2 set.
  function automatic logic [31:0] sel_inst(input logic [XLEN-1:0] data,
                                           input logic            upper);
    if ((XLEN == 64) && upper) begin
      return data[HI +: 32];
    end
    return data[31:0];
  endfunction

  // Tag FIFO storage and control.
  logic [XLEN-1:0] tag_mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   cnt_nxt;
  logic [CW-1:0]   drop_nxt;
  logic [CW:0]     occupancy;
  logic [XLEN-1:0] head_tag;

  // Per-cycle events.
  logic stall;
  logic ar_ok;
  logic push;
  logic draining;
  logic rready;
  logic beat;
  logic drop_beat;
  logic pop;
  logic load;
  logic out_take;

  // Output register.
  logic            vld_p1;
  logic [31:0]     inst_p1;
  logic [XLEN-1:0] pc_p1;
  logic            fault_p1;

  // Only rresp[1] distinguishes an error; OKAY/EXOKAY are equivalent here.
  logic unused_rresp0;
  assign unused_rresp0 = bus.i_rresp[0];

  assign occupancy = {1'b0, cnt} + {1'b0, drop_cnt};
  assign stall     = (occupancy == DEPTH_W);

  // An AR fired while stalled is a protocol error; refusing it keeps the
  // counters inside the budget.
  assign ar_ok     = bus.i_ar_fire & ~stall;
  assign push      = ar_ok & ~bus.i_flush;

  // Beats owed to flushed reads are accepted unconditionally so they never
  // block the new path behind a stalled decode.
  assign draining  = (drop_cnt != '0);
  assign rready    = draining | ((cnt != '0) & (~vld_p1 | bus.i_ready));
  assign beat      = bus.i_rvalid & rready;
  assign drop_beat = beat & draining;
  assign pop       = beat & ~draining;
  assign load      = pop & ~bus.i_flush;
  assign out_take  = vld_p1 & bus.i_ready;

  assign head_tag  = tag_mem[rd_ptr];

  always_comb begin
    cnt_nxt  = cnt;
    drop_nxt = drop_cnt;
    if (bus.i_flush) begin
      // Everything live, plus an AR firing now, becomes owed; a beat taken
      // this cycle settles one of them whichever counter it came from.
      cnt_nxt  = '0;
      drop_nxt = drop_cnt + cnt + CW'(ar_ok) - CW'(beat);
    end else begin
      cnt_nxt  = cnt + CW'(push) - CW'(pop);
      drop_nxt = drop_cnt - CW'(drop_beat);
    end
  end

  // ---- stage p0: request tracking (tag FIFO) ----
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      drop_cnt <= '0;
    end else begin
      cnt      <= cnt_nxt;
      drop_cnt <= drop_nxt;
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      // push is blocked during a flush, so wr_ptr is already final here.
      if (bus.i_flush) begin
        rd_ptr <= wr_ptr;
      end else if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wr_ptr] <= bus.i_ar_addr;
    end
  end

  // ---- stage p1: instruction output register ----
  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld_p1   <= 1'b0;
      inst_p1  <= '0;
      pc_p1    <= '0;
      fault_p1 <= 1'b0;
    end else begin
      if (bus.i_flush) begin
        vld_p1 <= 1'b0;
      end else if (load) begin
        vld_p1 <= 1'b1;
      end else if (out_take) begin
        vld_p1 <= 1'b0;
      end
      if (load) begin
        inst_p1  <= sel_inst(bus.i_rdata, head_tag[2]);
        pc_p1    <= head_tag;
        fault_p1 <= bus.i_rresp[1];
      end
    end
  end

  assign bus.o_stall  = stall;
  assign bus.o_rready = rready;
  assign bus.o_valid  = vld_p1;
  assign bus.o_inst   = inst_p1;
  assign bus.o_pc     = pc_p1;
  assign bus.o_fault  = fault_p1;

  ap_rvalid_known: assert property (@(posedge clk) disable iff (!rstn)
    !$isunknown(bus.i_rvalid));

  ap_no_stray_beat: assert property (@(posedge clk) disable iff (!rstn)
    !(bus.i_rvalid && (cnt == '0) && (drop_cnt == '0)));

  ap_budget: assert property (@(posedge clk) disable iff (!rstn)
    occupancy <= DEPTH_W);

  ap_no_ar_when_stalled: assert property (@(posedge clk) disable iff (!rstn)
    !(bus.i_ar_fire && stall));

  ap_rready_idle: assert property (@(posedge clk) disable iff (!rstn)
    !(rready && (cnt == '0) && (drop_cnt == '0)));

endmodule

// File: doc/fetch_resp_buffer.md
Name: fetch_resp_buffer

Overview:
- Sits directly downstream of the fetch stage.
- Tracks outstanding instruction-memory reads issued on the AXI-lite AR channel by storing each request's PC in a tag FIFO.
- Consumes the R channel and presents one instruction with its PC to decode over a valid/ready handshake.
- On a redirect (jump/branch), discards all in-flight reads and their late-arriving responses, and raises a stall toward fetch when the outstanding-read budget is exhausted.

Parameters:
- XLEN, 64, data/address width; R data width equals XLEN (32 or 64 only).
- DEPTH, 4, maximum outstanding reads (tag FIFO depth); power of two, at least 2.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- i_ar_fire  in  1  AR handshake completed this cycle (arvalid & arready at fetch)
- i_ar_addr  in  XLEN  araddr (PC) of the fired request
- i_flush  in  1  redirect this cycle (jump or taken branch)
- o_stall  out  1  outstanding budget full; fetch must treat as halt
- i_rvalid  in  1  AXI-lite R valid
- i_rdata  in  XLEN  AXI-lite R data
- i_rresp  in  2  AXI-lite R response
- o_rready  out  1  AXI-lite R ready
- o_valid  out  1  instruction valid to decode
- i_ready  in  1  decode ready
- o_inst  out  32  instruction word
- o_pc  out  XLEN  PC of o_inst
- o_fault  out  1  access fault: rresp was SLVERR or DECERR (rresp[1]=1)

Behaviour:
- Reset (rstn=0 at a clk edge): tag FIFO empty (cnt=0), drop_cnt=0, o_valid=0, o_inst=0, o_pc=0, o_fault=0. Consequently o_rready=0 and o_stall=0. Reset mid-operation abandons all state; no response after reset is attributed to pre-reset requests.
- State:
  - cnt: tag FIFO occupancy, 0..DEPTH.
  - drop_cnt: responses still owed to flushed requests, 0..DEPTH.
  - Invariant: cnt + drop_cnt <= DEPTH.
  - 1-entry output register {o_valid, o_inst, o_pc, o_fault}.
- o_stall = (cnt + drop_cnt == DEPTH); combinational.
- i_ar_fire while o_stall=1 is a protocol violation. The request is not enqueued; simulation assertion fires.
- Enqueue: i_ar_fire and no i_flush pushes i_ar_addr into the tag FIFO.
- o_rready (combinational):
  - 1 if drop_cnt > 0.
  - Otherwise 1 iff cnt > 0 and (o_valid=0 or i_ready=1).
  - Never asserted with cnt=0 and drop_cnt=0.
- R beat (i_rvalid & o_rready):
  - If drop_cnt > 0: beat discarded, drop_cnt decrements, tag FIFO untouched.
  - Otherwise: pop tag T; next cycle o_valid=1, o_pc=T, o_fault=i_rresp[1].
  - o_inst = i_rdata[63:32] if XLEN=64 and T[2]=1; else i_rdata[31:0].
  - Latency: beat accepted at cycle N gives o_valid at N+1.
  - Throughput: one instruction per cycle with i_ready held high.
- Output handshake: o_valid & i_ready consumes the entry. If no new beat loads in the same cycle, o_valid clears next cycle. Outputs hold stable while o_valid=1 and i_ready=0.
- Flush (i_flush=1 at cycle N), effective at N+1:
  - o_valid=0.
  - cnt=0.
  - drop_cnt = drop_cnt + cnt + i_ar_fire − (i_rvalid & o_rready).
  - An AR firing in the flush cycle belongs to the old path and is dropped.
  - An R beat accepted in the flush cycle is discarded, never loaded.
  - An output handshake completing in the flush cycle still counts as consumed by decode.
- Simultaneous push and pop in one cycle: cnt unchanged; FIFO ordering preserved.
- Pointers wrap modulo DEPTH.
- Assertions:
  - No R beat arrives while cnt=0 and drop_cnt=0 (X-check).
  - cnt + drop_cnt <= DEPTH.

Test Plan:
- Single fetch: reset, then AR fire with addr 0x1000; R beat 2 cycles later with rdata=0x0000_0013_0000_0093, rresp=0 -> next cycle o_valid=1, o_pc=0x1000, o_inst=0x00000093, o_fault=0. With addr 0x1004 -> o_inst=0x00000013.
- Streaming/backpressure: 4 AR fires at 0x1000..0x100C (DEPTH=4) -> o_stall=1 after the 4th. With i_ready=0, o_rready=0 once o_valid=1; release i_ready -> four instructions in order, one per cycle, PCs 0x1000..0x100C.
- Flush with 3 outstanding: i_flush -> o_valid=0 next cycle, drop_cnt=3. Next 3 R beats accepted with o_rready=1 and never appear on o_valid. The 4th beat, tagged with post-flush AR addr 0x2000, appears with o_pc=0x2000.
- Flush coincident with AR fire and R beat (cnt=2): drop_cnt becomes 2+1−1=2, cnt=0, o_valid=0.
- Error response: R beat with rresp=2'b10 for PC 0x1008 -> o_valid=1, o_fault=1, o_pc=0x1008.
- Reset mid-stream (cnt=3, o_valid=1, i_ready=0): rstn low for 1 cycle -> o_valid=0, o_rready=0, o_stall=0; a new AR after reset produces a correctly tagged instruction.
